// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - pipeline-side request/response bundle for the mul/div sequencer
interface muldiv_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             istart;
   logic [1:0]       iop;
   logic [WIDTH-1:0] iA;
   logic [WIDTH-1:0] iB;
   logic             iwe_hi;
   logic             iwe_lo;
   logic [WIDTH-1:0] iwdata;
   logic             oStall;
   logic             oBusy;
   logic             oDone;
   logic [WIDTH-1:0] oHI;
   logic [WIDTH-1:0] oLO;

   // Pipeline (EX stage) side
   modport master (
      output istart, iop, iA, iB, iwe_hi, iwe_lo, iwdata,
      input  oStall, oBusy, oDone, oHI, oLO
   );

   // Sequencer side
   modport slave (
      input  istart, iop, iA, iB, iwe_hi, iwe_lo, iwdata,
      output oStall, oBusy, oDone, oHI, oLO
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           op_q, op_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   logic                 div_zero_q, div_zero_d;
   // Multiplicand for multiply, divisor for divide (always a magnitude)
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   // Multiply: {partial product, multiplier}; divide: {remainder, quotient}
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 stall;

   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       add_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   // Operand magnitudes at issue; 0x80000000 maps to unsigned 2^31 without overflow
   always_comb begin
      a_neg = bus.iop[0] & bus.iA[WIDTH-1];
      b_neg = bus.iop[0] & bus.iB[WIDTH-1];
      a_mag = a_neg ? -bus.iA : bus.iA;
      b_mag = b_neg ? -bus.iB : bus.iB;
   end

   // One iteration of shift-add multiply and restoring divide, plus sign fix-up
   always_comb begin
      add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {add_sum, acc_q[WIDTH-1:1]};

      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      diff     = rem_sh - {1'b0, opnd_q};
      div_next = diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

      prod_fix = (op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
      quo_fix  = acc_q[WIDTH-1:0];
      rem_fix  = acc_q[2*WIDTH-1:WIDTH];
      if (op_q[0] && (sign_a_q ^ sign_b_q)) begin
         quo_fix = -acc_q[WIDTH-1:0];
      end
      if (op_q[0] && sign_a_q) begin
         rem_fix = -acc_q[2*WIDTH-1:WIDTH];
      end
      // Divide by zero reports all ones regardless of operand signs
      if (div_zero_q) begin
         quo_fix = '1;
      end
   end

   // Next-state, datapath and stall decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      div_zero_d = div_zero_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      stall      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.istart) begin
               // Start wins over MTHI/MTLO in the same cycle
               stall      = 1'b1;
               op_d       = bus.iop;
               sign_a_d   = a_neg;
               sign_b_d   = b_neg;
               div_zero_d = (bus.iB == '0);
               opnd_d     = bus.iop[1] ? b_mag : a_mag;
               acc_d      = {{WIDTH{1'b0}}, (bus.iop[1] ? a_mag : b_mag)};
               cnt_d      = CNT_INIT;
               state_d    = S_RUN;
            end else begin
               if (bus.iwe_hi) hi_d = bus.iwdata;
               if (bus.iwe_lo) lo_d = bus.iwdata;
            end
         end
         S_RUN: begin
            stall = 1'b1;
            if (cnt_q != '0) begin
               acc_d = op_q[1] ? div_next : mul_next;
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            stall   = 1'b1;
            hi_d    = op_q[1] ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_d    = op_q[1] ? quo_fix : prod_fix[WIDTH-1:0];
            state_d = S_DONE;
         end
         S_DONE: begin
            // EX only presents the next instruction once back in IDLE
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   // State register; reset abandons any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         div_zero_q <= 1'b0;
         opnd_q     <= '0;
         acc_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         div_zero_q <= div_zero_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.oStall = stall;
   assign bus.oBusy  = busy_q;
   assign bus.oDone  = done_q;
   assign bus.oHI    = hi_q;
   assign bus.oLO    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errs = 0;
   logic [31:0] mdl_hi = 32'h0;
   logic [31:0] mdl_lo = 32'h0;

   muldiv_ctrl_if #(.WIDTH(32)) bus ();

   muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one operation and follow it to oDone; optional interference during RUN
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit disturb, input bit we_start);
      int cyc;
      int stall_bad;
      bit done;
      @(posedge clk); #1;
      bus.istart = 1'b1;
      bus.iop    = op;
      bus.iA     = a;
      bus.iB     = b;
      if (we_start) begin
         bus.iwe_lo = 1'b1;
         bus.iwdata = 32'hAAAA_5555;
      end
      #1;
      check_eq({tag, "_stall_issue"}, 64'(bus.oStall), 64'd1);
      @(posedge clk); #1;
      bus.istart = 1'b0;
      bus.iwe_lo = 1'b0;
      cyc = 0;
      stall_bad = 0;
      done = 1'b0;
      while (!done && cyc < 60) begin
         if (disturb && cyc == 5) begin
            bus.istart = 1'b1;
            bus.iop    = 2'b10;
            bus.iA     = 32'd9;
            bus.iB     = 32'd4;
            bus.iwe_lo = 1'b1;
            bus.iwdata = 32'hDEAD_BEEF;
         end
         if (disturb && cyc == 6) begin
            bus.istart = 1'b0;
            bus.iwe_lo = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
         if (bus.oDone) done = 1'b1;
         else if (!bus.oStall || !bus.oBusy) stall_bad++;
         if (disturb && cyc == 8) begin
            check_eq({tag, "_hold_hi"}, 64'(bus.oHI), 64'(mdl_hi));
            check_eq({tag, "_hold_lo"}, 64'(bus.oLO), 64'(mdl_lo));
         end
      end
      check_eq({tag, "_latency"}, 64'(cyc), 64'd34);
      check_eq({tag, "_stall_run"}, 64'(stall_bad), 64'd0);
      check_eq({tag, "_stall_done"}, 64'(bus.oStall), 64'd0);
      check_eq({tag, "_hi"}, 64'(bus.oHI), 64'(exp_hi));
      check_eq({tag, "_lo"}, 64'(bus.oLO), 64'(exp_lo));
      mdl_hi = exp_hi;
      mdl_lo = exp_lo;
      @(posedge clk); #1;
      check_eq({tag, "_done_pulse"}, 64'(bus.oDone), 64'd0);
   endtask

   initial begin
      int pulses;
      bus.istart = 1'b0;
      bus.iop    = 2'b00;
      bus.iA     = '0;
      bus.iB     = '0;
      bus.iwe_hi = 1'b0;
      bus.iwe_lo = 1'b0;
      bus.iwdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_hi", 64'(bus.oHI), 64'd0);
      check_eq("rst_lo", 64'(bus.oLO), 64'd0);
      check_eq("rst_busy", 64'(bus.oBusy), 64'd0);
      check_eq("rst_done", 64'(bus.oDone), 64'd0);
      check_eq("rst_stall", 64'(bus.oStall), 64'd0);

      run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
      run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
      run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
      run_op("divu_zero", 2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0, 0);
      run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);

      // Reset ten cycles into a DIVU 100/7
      @(posedge clk); #1;
      bus.istart = 1'b1;
      bus.iop    = 2'b10;
      bus.iA     = 32'd100;
      bus.iB     = 32'd7;
      @(posedge clk); #1;
      bus.istart = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("mid_rst_busy", 64'(bus.oBusy), 64'd0);
      check_eq("mid_rst_stall", 64'(bus.oStall), 64'd0);
      check_eq("mid_rst_hi", 64'(bus.oHI), 64'd0);
      check_eq("mid_rst_lo", 64'(bus.oLO), 64'd0);
      rst = 1'b0;
      mdl_hi = 32'h0;
      mdl_lo = 32'h0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.oDone) pulses++;
      end
      check_eq("mid_rst_no_done", 64'(pulses), 64'd0);

      // MTHI in IDLE
      bus.iwe_hi = 1'b1;
      bus.iwdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus.iwe_hi = 1'b0;
      check_eq("mthi", 64'(bus.oHI), 64'h1234_5678);
      mdl_hi = 32'h1234_5678;

      run_op("multu_disturb", 2'b00, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1, 0);
      run_op("start_vs_mtlo", 2'b00, 32'd2, 32'd2, 32'h0000_0000, 32'h0000_0004, 0, 1);

      // MTHI and MTLO together
      bus.iwe_hi = 1'b1;
      bus.iwe_lo = 1'b1;
      bus.iwdata = 32'h0000_0055;
      @(posedge clk); #1;
      bus.iwe_hi = 1'b0;
      bus.iwe_lo = 1'b0;
      check_eq("mthilo_hi", 64'(bus.oHI), 64'h55);
      check_eq("mthilo_lo", 64'(bus.oLO), 64'h55);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
